gate_tester: RTL and testbench
==============================

# gate_tester

Stimulus generator and response checker for a small combinational gate under test. On a start request it sweeps every input combination onto `stim`, waits a settle interval, samples the gate's `resp` and compares it against a golden model selected by `gate_sel`. It reports a pass/fail verdict, an error count and the first failing vector. It sits opposite the gate tiles and drives their `ui_in` pins from on-chip logic.

## Interface
- `N_IN`, default 2: number of gate inputs; sweep length is 2^N_IN vectors; legal range 1..6.
- `SETTLE`, default 2: wait cycles per vector before sampling; legal range 1..15.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled request to begin a sweep; honoured only in IDLE.
- `gate_sel` in 3: expected function; 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6 and 7 expect constant 0. Latched on accepted start.
- `resp` in 1: gate output; same clock domain; combinational from `stim`.
- `stim` out N_IN: vector driven to the gate; registered.
- `busy` out 1: high while a sweep is in progress.
- `done` out 1: one-cycle pulse after the last sample.
- `pass` out 1: 1 when the last completed sweep had zero errors; held until the next accepted start.
- `err_count` out N_IN+1: number of mismatching vectors in the current or last sweep.
- `first_fail` out N_IN: stim value of the first mismatch; valid when `fail_seen`.
- `fail_seen` out 1: sticky within a sweep; set on the first mismatch.

## Operation
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE: `stim` = 0. On `start` = 1: latch `gate_sel`, clear `err_count`, `first_fail`, `fail_seen` and `pass`, and go to RUN.
- RUN: the settle counter `cnt` runs from 0 to SETTLE while `stim` is held. When `cnt` = SETTLE, compare `resp` with the model output for the current `stim`.
  - On mismatch: increment `err_count`. If `fail_seen` = 0, set it and capture `stim` into `first_fail`.
  - Then either increment `stim` and reset `cnt`, or, if `stim` is all ones, go to DONE.
- DONE: pulse `done`, register `pass = (err_count == 0)`, clear `stim` to 0, return to IDLE.
- `start` during RUN or DONE is ignored.
- `stim` wraps only through DONE and never rolls over inside a sweep.
- The model reduces over all N_IN bits: AND/OR/XOR are reductions and NAND/NOR/XNOR are their inversions.
- `err_count` cannot overflow: its maximum is 2^N_IN.
- Reset in any state: next cycle is IDLE with all outputs 0, and the sweep is abandoned.

## Timing
- Reset values: `stim`, `busy`, `done`, `pass`, `err_count`, `first_fail` and `fail_seen` are all 0.
- Start accepted at cycle 0 (edge where IDLE sees `start`). `busy` = 1 and `stim` = 0 from cycle 1.
- Each vector occupies SETTLE+1 cycles. Vector k is sampled at cycle (k+1)(SETTLE+1).
- Last sample at cycle T = 2^N_IN·(SETTLE+1).
- At cycle T+1: `done` = 1, `busy` = 0, `pass` valid. At cycle T+2: IDLE; a new start is accepted from this cycle.
- Defaults: sampling at cycles 3, 6, 9, 12; `done` at cycle 13.
- `err_count`/`fail_seen` update in the cycle after the sample edge.

## Configuration
- `GATE_TESTER_LOOP_EN` defined: if `start` = 1 during DONE, the FSM goes directly to RUN.
  - Clears the counters, relatches `gate_sel`, `stim` = 0, `busy` = 1 in the following cycle.
  - `done` and `pass` still update for the finished sweep.
- Not defined: DONE always returns to IDLE, and back-to-back sweeps cost one extra IDLE cycle.

## Structure
- Package `gate_tester_pkg` holds:
  - the `gate_op_t` enum for codes 0–5;
  - the FSM state enum;
  - the constants `N_IN_MAX` = 6 and `SETTLE_MAX` = 15.
- Sub-module `gate_model`: combinational golden model (`gate_sel`, vector → expected bit), parameterised by N_IN, reusable by other gate-tile testers.
- Top module: FSM, settle counter, `stim` register, error bookkeeping.

## Test plan
- Healthy AND: `gate_sel` = 0, `resp` = &`stim`, start at cycle 0 → `done` at cycle 13, `pass` = 1, `err_count` = 0, `fail_seen` = 0.
- Stuck-at-0 with AND: `resp` = 0 → `err_count` = 1, `first_fail` = 2'b11, `pass` = 0.
- Stuck-at-1 with NOR: `gate_sel` = 3, `resp` = 1 → `err_count` = 3, `first_fail` = 2'b01, `pass` = 0.
- Reset mid-run: `rst` at cycle 5 → cycle 6 has all outputs 0 and FSM in IDLE; a fresh start then completes normally with `pass` = 1.
- Start during RUN: pulse `start` at cycle 4 with `gate_sel` = 1 → ignored; sweep still checks AND and `done` is still at cycle 13.
- Loop mode (macro defined): hold `start` = 1 → `done` at cycles 13 and 26; `busy` stays high across the boundary except cycle 13.

Source files
------------

// File: rtl/gate_tester_pkg.sv
// Shared types and limits for the gate tester and its golden model.
package gate_tester_pkg;

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpOr   = 3'd1,
        OpNand = 3'd2,
        OpNor  = 3'd3,
        OpXor  = 3'd4,
        OpXnor = 3'd5
    } gate_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned N_IN_MAX   = 6;
    localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/gate_tester_model.sv
// Combinational golden model: expected gate output for a vector, reduced over all N_IN bits.
module gate_model
    import gate_tester_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic [2:0]      gate_sel,
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    always_comb begin
        expected = 1'b0;
        case (gate_sel)
            OpAnd:   expected = &vec;
            OpOr:    expected = |vec;
            OpNand:  expected = ~&vec;
            OpNor:   expected = ~|vec;
            OpXor:   expected = ^vec;
            OpXnor:  expected = ~^vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tester.sv
// Sweeps every input vector onto a gate, samples its response after a settle interval and
// checks it against gate_model. Define GATE_TESTER_LOOP_EN to restart directly from DONE.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      gate_sel,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_seen
);

    localparam int unsigned CntW = $clog2(SETTLE_MAX + 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [2:0]      sel_q, sel_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            fs_q, fs_d;
    logic            pass_q, pass_d;
    logic            expected;

    gate_model #(
        .N_IN (N_IN)
    ) u_model (
        .gate_sel (sel_q),
        .vec      (stim_q),
        .expected (expected)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        sel_d   = sel_q;
        err_d   = err_q;
        ff_d    = ff_q;
        fs_d    = fs_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                stim_d = '0;
                cnt_d  = '0;
                if (start) begin
                    sel_d   = gate_sel;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                    pass_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cnt_q == CntW'(SETTLE)) begin
                    if (resp != expected) begin
                        err_d = err_q + 1'b1;
                        if (!fs_q) begin
                            fs_d = 1'b1;
                            ff_d = stim_q;
                        end
                    end
                    // Verdict registers on the last sample so it is valid alongside done.
                    if (&stim_q) begin
                        pass_d  = (err_d == '0);
                        state_d = StDone;
                    end else begin
                        stim_d = stim_q + 1'b1;
                        cnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                stim_d  = '0;
                cnt_d   = '0;
                state_d = StIdle;
`ifdef GATE_TESTER_LOOP_EN
                // Pass is kept so the finished sweep's verdict stays visible.
                if (start) begin
                    sel_d   = gate_sel;
                    err_d   = '0;
                    ff_d    = '0;
                    fs_d    = 1'b0;
                    state_d = StRun;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stim_q  <= '0;
            sel_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fs_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fs_q    <= fs_d;
            pass_q  <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_seen  = fs_q;

endmodule

// File: tb/tb_gate_tester.sv
// Self-checking bench for gate_tester: directed and random sweeps against a truth-count model.
module tb_gate_tester;

    localparam int N = 2;
    localparam int S = 2;
    localparam int V = 1 << N;
    localparam int T = V * (S + 1);
`ifdef GATE_TESTER_LOOP_EN
    localparam int LOOP = 1;
`else
    localparam int LOOP = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     gate_sel;
    logic           resp;
    logic [N-1:0]   stim;
    logic           busy;
    logic           done;
    logic           pass;
    logic [N:0]     err_count;
    logic [N-1:0]   first_fail;
    logic           fail_seen;
    logic [V-1:0]   resp_tbl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Gate under test: a truth table indexed by the driven vector.
    assign resp = resp_tbl[stim];

    gate_tester #(
        .N_IN   (N),
        .SETTLE (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .gate_sel   (gate_sel),
        .resp       (resp),
        .stim       (stim),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    function automatic logic model_bit(input logic [2:0] sel, input int v);
        int ones;
        ones = 0;
        for (int i = 0; i < N; i++) ones += (v >> i) & 1;
        case (sel)
            3'd0:    return ones == N;
            3'd1:    return ones > 0;
            3'd2:    return ones != N;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [V-1:0] golden_tbl(input logic [2:0] sel);
        logic [V-1:0] t;
        for (int v = 0; v < V; v++) t[v] = model_bit(sel, v);
        return t;
    endfunction

    // Mismatches whose sample edge lies strictly before cycle c.
    function automatic int errs_before(input logic [2:0] sel, input logic [V-1:0] tbl, input int c);
        int e;
        e = 0;
        for (int k = 0; k < V; k++)
            if ((k + 1) * (S + 1) <= c - 1 && tbl[k] !== model_bit(sel, k)) e++;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string name, input logic [2:0] sel, input logic [V-1:0] tbl,
                         input int pulse_cyc, input logic [2:0] pulse_sel);
        int errs, ff, obs, done_cyc;
        errs = errs_before(sel, tbl, T + 1);
        ff = -1;
        for (int k = V - 1; k >= 0; k--) if (tbl[k] !== model_bit(sel, k)) ff = k;
        resp_tbl = tbl;
        @(negedge clk);
        gate_sel = sel;
        start    = 1'b1;
        step();
        start    = 1'b0;
        gate_sel = 3'($urandom);
        obs      = 1;
        done_cyc = -1;
        while (done_cyc < 0 && obs <= T + 3) begin
            if (done === 1'b1) begin
                done_cyc = obs;
            end else begin
                n_checks++;
                if (busy !== 1'b1 || stim !== N'((obs - 1) / (S + 1)) ||
                    err_count !== (N + 1)'(errs_before(sel, tbl, obs))) begin
                    n_fail++;
                    $display("FAIL %s run c%0d: busy=%b stim=%0d err=%0d, want busy=1 stim=%0d err=%0d",
                             name, obs, busy, stim, err_count, (obs - 1) / (S + 1),
                             errs_before(sel, tbl, obs));
                end
                if (obs == pulse_cyc) begin
                    start    = 1'b1;
                    gate_sel = pulse_sel;
                end
                step();
                start = 1'b0;
                obs++;
            end
        end
        n_checks++;
        if (done_cyc != T + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d, want %0d", name, done_cyc, T + 1);
        end
        n_checks++;
        if (busy !== 1'b0 || pass !== (errs == 0) || err_count !== (N + 1)'(errs) ||
            fail_seen !== (errs > 0) || (errs > 0 && first_fail !== N'(ff))) begin
            n_fail++;
            $display("FAIL %s verdict: busy=%b pass=%b err=%0d seen=%b first=%0d, want 0 %b %0d %b %0d",
                     name, busy, pass, err_count, fail_seen, first_fail,
                     errs == 0, errs, errs > 0, ff);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || stim !== '0 || pass !== (errs == 0)) begin
            n_fail++;
            $display("FAIL %s after_done: done=%b busy=%b stim=%0d pass=%b, want 0 0 0 %b",
                     name, done, busy, stim, pass, errs == 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; gate_sel = '0; resp_tbl = '0;
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({stim, busy, done, pass, err_count, first_fail, fail_seen} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: stim=%0d busy=%b done=%b pass=%b err=%0d first=%0d seen=%b, want all 0",
                     stim, busy, done, pass, err_count, first_fail, fail_seen);
        end
    endtask

    task automatic test_healthy_and();
        sweep("healthy_and", 3'd0, golden_tbl(3'd0), -1, 3'd0);
    endtask

    task automatic test_stuck_at_0_and();
        sweep("stuck0_and", 3'd0, '0, -1, 3'd0);
        n_checks++;
        if (err_count !== 3'd1 || first_fail !== 2'b11) begin
            n_fail++;
            $display("FAIL stuck0_and_const: err=%0d first=%b, want 1 11", err_count, first_fail);
        end
    endtask

    task automatic test_stuck_at_1_nor();
        sweep("stuck1_nor", 3'd3, '1, -1, 3'd0);
        n_checks++;
        if (err_count !== 3'd3 || first_fail !== 2'b01) begin
            n_fail++;
            $display("FAIL stuck1_nor_const: err=%0d first=%b, want 3 01", err_count, first_fail);
        end
    endtask

    task automatic test_start_during_run();
        sweep("start_in_run", 3'd0, golden_tbl(3'd0), 4, 3'd1);
    endtask

    task automatic test_random();
        logic [2:0]   sel;
        logic [V-1:0] mask;
        for (int i = 0; i < 10; i++) begin
            sel  = 3'($urandom_range(0, 7));
            mask = (i % 3 == 0) ? '0 : V'($urandom);
            sweep($sformatf("random%0d", i), sel, golden_tbl(sel) ^ mask, -1, 3'd0);
        end
    endtask

    task automatic test_reset_mid_run();
        int obs;
        resp_tbl = golden_tbl(3'd0);
        @(negedge clk);
        gate_sel = 3'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        obs   = 1;
        while (obs < 5) begin
            step();
            obs++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({stim, busy, done, pass, err_count, first_fail, fail_seen} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: stim=%0d busy=%b done=%b err=%0d seen=%b, want all 0",
                     stim, busy, done, err_count, fail_seen);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || stim !== '0) begin
            n_fail++;
            $display("FAIL reset_stays_idle: busy=%b stim=%0d, want 0 0", busy, stim);
        end
        sweep("after_reset", 3'd0, golden_tbl(3'd0), -1, 3'd0);
    endtask

    task automatic test_back_to_back();
        int obs, n_done, d0, d1, n_low, exp_d1, exp_low;
        resp_tbl = golden_tbl(3'd4);
        @(negedge clk);
        gate_sel = 3'd4;
        start    = 1'b1;
        step();
        obs = 1; n_done = 0; d0 = -1; d1 = -1; n_low = 0;
        while (obs <= 2 * T + 4) begin
            if (obs == T + 3) start = 1'b0;
            if (done === 1'b1) begin
                if (n_done == 0) d0 = obs;
                else if (n_done == 1) d1 = obs;
                n_done++;
            end
            if (obs <= d1 || d1 < 0) if (busy !== 1'b1) n_low++;
            step();
            obs++;
        end
        exp_d1  = (LOOP != 0) ? 2 * T + 2 : 2 * T + 3;
        exp_low = (LOOP != 0) ? 2 : 3;
        n_checks++;
        if (d0 != T + 1 || d1 != exp_d1 || n_done != 2) begin
            n_fail++;
            $display("FAIL back_to_back_done: d0=%0d d1=%0d n=%0d, want %0d %0d 2",
                     d0, d1, n_done, T + 1, exp_d1);
        end
        n_checks++;
        if (n_low != exp_low || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_busy: idle_cycles=%0d pass=%b, want %0d 1",
                     n_low, pass, exp_low);
        end
    endtask

    initial begin
        test_reset();
        test_healthy_and();
        test_stuck_at_0_and();
        test_stuck_at_1_nor();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
